// File: rtl/disp_filter_pkg.sv
// Shared types and helpers for the disparity/confidence sequencer.
// Contents: sequencer FSM state enum, pipeline flush length, block geometry
// helpers and a counter-width helper.
package disp_filter_pkg;

   // Cycles spent in FLUSH to let the processor pipeline drain.
   localparam int unsigned FLUSH_LEN = 3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ALIGN = 3'd1,
      ST_RUN   = 3'd2,
      ST_FLUSH = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_t;

   // Blocks per block row.
   function automatic int unsigned blk_cols(input int unsigned width, input int unsigned dec);
      return width / dec;
   endfunction

   // Block rows per frame.
   function automatic int unsigned blk_rows(input int unsigned height, input int unsigned dec);
      return height / dec;
   endfunction

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/block_pos_counter.sv
// Column/row wrap counter over a grid of blocks.
// Ports: clk, reset (sync, active-high), clear (sync clear), advance (step one
// block), last_col / last_row (current position is last column / last row).
// Wraps column at num_cols-1 into the next row and row at num_rows-1 to zero.
module block_pos_counter
   import disp_filter_pkg::*;
#(
   parameter int unsigned num_cols = 4,
   parameter int unsigned num_rows = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic advance,
   output logic last_col,
   output logic last_row
);

   localparam int unsigned CW = cnt_width(num_cols);
   localparam int unsigned RW = cnt_width(num_rows);

   logic [CW-1:0] col;
   logic [RW-1:0] row;

   assign last_col = (col == CW'(num_cols - 1));
   assign last_row = (row == RW'(num_rows - 1));

   // Position register
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         col <= '0;
         row <= '0;
      end else if (advance) begin
         if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

endmodule

// File: rtl/disp_conf_sequencer.sv
// Frame-level sequencer for the disparity/confidence pixel processor.
// Gates upstream beats into the processor (proc_*), re-aligns the processor at
// each frame start, tags processor results with last-column / last-row markers
// and checks that each frame yields exactly BLK_COLS*BLK_ROWS results.
// Ports:
//   clk, reset (sync, active-high); start, abort: frame control
//   in_valid/in_ready + pixels_in/disp_in/conf_in: upstream beat stream
//   proc_reset, proc_valid, proc_pixels/proc_disp/proc_conf: processor inputs
//   proc_out_valid, proc_disp_conf, proc_conf_out: processor results
//   out_valid, out_disp_conf, out_conf, out_last_col, out_last_row: tagged results
//   busy, frame_done (pulse), count_err (sticky)
// Optional: define DISP_SEQ_STATS_EN to add stat_conf_sum / stat_zero_blocks.
module disp_conf_sequencer
   import disp_filter_pkg::*;
#(
   parameter int unsigned disp_bits  = 5,
   parameter int unsigned dec_factor = 2,
   parameter int unsigned img_width  = 640,
   parameter int unsigned img_height = 480
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [dec_factor-1:0]  pixels_in,
   input  logic [disp_bits-1:0]   disp_in,
   input  logic [7:0]             conf_in,
   output logic                   proc_reset,
   output logic                   proc_valid,
   output logic [dec_factor-1:0]  proc_pixels,
   output logic [disp_bits-1:0]   proc_disp,
   output logic [7:0]             proc_conf,
   input  logic [8+disp_bits-1:0] proc_disp_conf,
   input  logic [7:0]             proc_conf_out,
   input  logic                   proc_out_valid,
   output logic                   out_valid,
   output logic [8+disp_bits-1:0] out_disp_conf,
   output logic [7:0]             out_conf,
   output logic                   out_last_col,
   output logic                   out_last_row,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   count_err
`ifdef DISP_SEQ_STATS_EN
   ,
   output logic [31:0]            stat_conf_sum,
   output logic [31:0]            stat_zero_blocks
`endif
);

   localparam int unsigned BLK_COLS = blk_cols(img_width, dec_factor);
   localparam int unsigned BLK_ROWS = blk_rows(img_height, dec_factor);
   localparam int unsigned BLOCKS   = BLK_COLS * BLK_ROWS;
   localparam int unsigned PW       = cnt_width(dec_factor);
   localparam int unsigned OCW      = cnt_width(BLOCKS + 2);
   localparam int unsigned FW       = cnt_width(FLUSH_LEN);

   seq_state_t     state, next_state;
   logic           fire, abort_hit, clear_ctrs;
   logic [PW-1:0]  phase;
   logic           phase_last, in_last_col, in_last_row, last_beat;
   logic [FW-1:0]  flush_cnt;
   logic           flush_last;
   logic [OCW-1:0] out_blk_cnt, blk_cnt_nxt;
   logic           out_ok;

   assign fire       = in_valid && in_ready;
   assign abort_hit  = abort && (state != ST_IDLE);
   assign clear_ctrs = (state == ST_ALIGN) || abort_hit;
   assign phase_last = (phase == PW'(dec_factor - 1));
   assign last_beat  = fire && phase_last && in_last_col && in_last_row;
   assign flush_last = (flush_cnt == FW'(FLUSH_LEN - 1));

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Next-state logic; abort overrides everything outside IDLE
   always_comb begin
      next_state = state;
      unique case (state)
         ST_IDLE:  if (start) next_state = ST_ALIGN;
         ST_ALIGN: next_state = ST_RUN;
         ST_RUN:   if (last_beat) next_state = ST_FLUSH;
         ST_FLUSH: if (flush_last) next_state = ST_DONE;
         ST_DONE:  next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
      if (abort_hit) next_state = ST_IDLE;
   end

   // Registered control outputs, decoded from the state being entered
   always_ff @(posedge clk) begin
      if (reset) begin
         in_ready   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         proc_reset <= 1'b1;
      end else begin
         in_ready   <= (next_state == ST_RUN);
         busy       <= (next_state != ST_IDLE);
         frame_done <= (next_state == ST_DONE);
         proc_reset <= (next_state == ST_ALIGN) || abort_hit;
      end
   end

   // Flush length counter, idle at zero outside FLUSH
   always_ff @(posedge clk) begin
      if (reset || state != ST_FLUSH) flush_cnt <= '0;
      else                            flush_cnt <= flush_cnt + FW'(1);
   end

   // Beat phase within the current input block
   always_ff @(posedge clk) begin
      if (reset || clear_ctrs) phase <= '0;
      else if (fire)           phase <= phase_last ? '0 : phase + PW'(1);
   end

   block_pos_counter #(.num_cols(BLK_COLS), .num_rows(BLK_ROWS)) u_in_pos (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear_ctrs),
      .advance  (fire && phase_last),
      .last_col (in_last_col),
      .last_row (in_last_row)
   );

   // Processor input register; a beat caught by abort is not forwarded
   always_ff @(posedge clk) begin
      if (reset) begin
         proc_valid  <= 1'b0;
         proc_pixels <= '0;
         proc_disp   <= '0;
         proc_conf   <= '0;
      end else begin
         proc_valid <= fire && !abort_hit;
         if (fire) begin
            proc_pixels <= pixels_in;
            proc_disp   <= disp_in;
            proc_conf   <= conf_in;
         end
      end
   end

   // Result pass-through; results before RUN belong to no frame and are dropped
   assign out_ok        = proc_out_valid && (state inside {ST_RUN, ST_FLUSH, ST_DONE});
   assign out_valid     = out_ok;
   assign out_disp_conf = proc_disp_conf;
   assign out_conf      = proc_conf_out;

   block_pos_counter #(.num_cols(BLK_COLS), .num_rows(BLK_ROWS)) u_out_pos (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear_ctrs),
      .advance  (out_valid),
      .last_col (out_last_col),
      .last_row (out_last_row)
   );

   // Result count, saturating one past the expected total
   assign blk_cnt_nxt = (out_valid && out_blk_cnt != OCW'(BLOCKS + 1)) ?
                        out_blk_cnt + OCW'(1) : out_blk_cnt;

   always_ff @(posedge clk) begin
      if (reset || clear_ctrs) out_blk_cnt <= '0;
      else                     out_blk_cnt <= blk_cnt_nxt;
   end

   // Sticky integrity flag; sets take priority over the ALIGN clear
   always_ff @(posedge clk) begin
      if (reset) begin
         count_err <= 1'b0;
      end else begin
         if (state == ST_ALIGN)
            count_err <= 1'b0;
         if (proc_out_valid && !out_ok)
            count_err <= 1'b1;
         if (out_valid && out_blk_cnt >= OCW'(BLOCKS))
            count_err <= 1'b1;
         if (state == ST_DONE && blk_cnt_nxt != OCW'(BLOCKS))
            count_err <= 1'b1;
      end
   end

`ifdef DISP_SEQ_STATS_EN
   logic [32:0] conf_sum_ext;
   assign conf_sum_ext = {1'b0, stat_conf_sum} + 33'(out_conf);

   // Per-frame confidence statistics, saturating
   always_ff @(posedge clk) begin
      if (reset || state == ST_ALIGN) begin
         stat_conf_sum    <= '0;
         stat_zero_blocks <= '0;
      end else if (out_valid) begin
         stat_conf_sum <= conf_sum_ext[32] ? '1 : conf_sum_ext[31:0];
         if (out_conf == 8'd0 && stat_zero_blocks != '1)
            stat_zero_blocks <= stat_zero_blocks + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_disp_conf_sequencer.sv
// Directed bench for disp_conf_sequencer on an 8x4 image, decimation 2
// (4 block columns, 2 block rows, 16 beats per frame). A small processor
// model emits one result per two processor beats, one cycle after the second.
module tb_disp_conf_sequencer;

   localparam int DB = 5;
   localparam int DF = 2;
   localparam int BEATS = 16;
   localparam int NRES = 256;

   logic clk = 1'b0;
   logic reset, start, abort, in_valid, in_ready;
   logic [DF-1:0]   pixels_in;
   logic [DB-1:0]   disp_in;
   logic [7:0]      conf_in;
   logic            proc_reset, proc_valid;
   logic [DF-1:0]   proc_pixels;
   logic [DB-1:0]   proc_disp;
   logic [7:0]      proc_conf;
   logic [8+DB-1:0] proc_disp_conf;
   logic [7:0]      proc_conf_out;
   logic            proc_out_valid;
   logic            out_valid;
   logic [8+DB-1:0] out_disp_conf;
   logic [7:0]      out_conf;
   logic            out_last_col, out_last_row, busy, frame_done, count_err;
`ifdef DISP_SEQ_STATS_EN
   logic [31:0]     stat_conf_sum, stat_zero_blocks;
`endif

   always #5 clk = ~clk;

   disp_conf_sequencer #(.disp_bits(DB), .dec_factor(DF), .img_width(8), .img_height(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .abort          (abort),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .pixels_in      (pixels_in),
      .disp_in        (disp_in),
      .conf_in        (conf_in),
      .proc_reset     (proc_reset),
      .proc_valid     (proc_valid),
      .proc_pixels    (proc_pixels),
      .proc_disp      (proc_disp),
      .proc_conf      (proc_conf),
      .proc_disp_conf (proc_disp_conf),
      .proc_conf_out  (proc_conf_out),
      .proc_out_valid (proc_out_valid),
      .out_valid      (out_valid),
      .out_disp_conf  (out_disp_conf),
      .out_conf       (out_conf),
      .out_last_col   (out_last_col),
      .out_last_row   (out_last_row),
      .busy           (busy),
      .frame_done     (frame_done),
      .count_err      (count_err)
`ifdef DISP_SEQ_STATS_EN
      ,
      .stat_conf_sum    (stat_conf_sum),
      .stat_zero_blocks (stat_zero_blocks)
`endif
   );

   // Processor model: result = {conf, disp ^ pixels} of the block's second beat
   logic pm_phase, pm_valid, inj;
   always @(posedge clk) begin
      if (proc_reset) begin
         pm_phase <= 1'b0;
         pm_valid <= 1'b0;
      end else begin
         pm_valid <= 1'b0;
         if (proc_valid) begin
            pm_phase <= ~pm_phase;
            if (pm_phase) begin
               pm_valid       <= 1'b1;
               proc_disp_conf <= {proc_conf, proc_disp ^ DB'(proc_pixels)};
               proc_conf_out  <= proc_conf;
            end
         end
      end
   end
   assign proc_out_valid = pm_valid | inj;

   // Result / event monitor
   logic            res_col [NRES];
   logic            res_row [NRES];
   logic [7:0]      res_conf[NRES];
   logic [8+DB-1:0] res_dc  [NRES];
   int n_out = 0, n_done = 0, n_pv = 0;
   always @(negedge clk) begin
      if (out_valid) begin
         res_col[n_out % NRES]  <= out_last_col;
         res_row[n_out % NRES]  <= out_last_row;
         res_conf[n_out % NRES] <= out_conf;
         res_dc[n_out % NRES]   <= out_disp_conf;
         n_out <= n_out + 1;
      end
      if (frame_done) n_done <= n_done + 1;
      if (proc_valid) n_pv <= n_pv + 1;
   end

   int checks = 0, failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Start a frame and push nbeats beats with gap idle cycles after each
   task automatic run_frame(input int gap, input int mode, input bit hold, input int nbeats);
      int wait_cnt;
      start = 1'b1;
      tick;
      if (!hold) start = 1'b0;
      for (int b = 0; b < nbeats; b++) begin
         pixels_in = DF'(b);
         disp_in   = DB'(b);
         conf_in   = (mode == 0) ? 8'(10 + b) : ((b / 2 == 2) ? 8'd0 : 8'd40);
         in_valid  = 1'b1;
         wait_cnt  = 0;
         while (!in_ready && wait_cnt < 20) begin
            tick;
            wait_cnt++;
         end
         if (wait_cnt >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
         tick;
         in_valid = 1'b0;
         if (b == 0) check("proc_valid_latency", 32'(proc_valid), 32'd1);
         for (int g = 0; g < gap; g++) begin
            tick;
            if (b == 0 && g == 0) check("proc_valid_idle", 32'(proc_valid), 32'd0);
         end
      end
      if (nbeats == BEATS) begin
         wait_cnt = 0;
         while (!frame_done && wait_cnt < 20) begin
            tick;
            wait_cnt++;
         end
         check("frame_done_seen", 32'(frame_done), 32'd1);
      end
   endtask

   // Compare one complete frame's results against the expected block pattern
   task automatic check_frame(input string pfx, input int o0, input int d0, input int p0,
                              input int exp_sum);
      logic [7:0] cv, rv;
      int sum;
      sum = 0;
      for (int k = 0; k < 8; k++) begin
         cv[k] = res_col[(o0 + k) % NRES];
         rv[k] = res_row[(o0 + k) % NRES];
         sum += int'(res_conf[(o0 + k) % NRES]);
      end
      check({pfx, "_results"},    32'(n_out - o0), 32'd8);
      check({pfx, "_last_col"},   32'(cv), 32'h88);
      check({pfx, "_last_row"},   32'(rv), 32'hF0);
      check({pfx, "_conf_sum"},   32'(sum), 32'(exp_sum));
      check({pfx, "_frame_done"}, 32'(n_done - d0), 32'd1);
      check({pfx, "_proc_valid"}, 32'(n_pv - p0), 32'd16);
      check({pfx, "_count_err"},  32'(count_err), 32'd0);
   endtask

   int o0, d0, p0;

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; inj = 1'b0;
      pixels_in = '0; disp_in = '0; conf_in = '0;
      repeat (3) tick;
      check("rst_in_ready",   32'(in_ready),   32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_count_err",  32'(count_err),  32'd0);
      check("rst_proc_valid", 32'(proc_valid), 32'd0);
      check("rst_proc_reset", 32'(proc_reset), 32'd1);
      reset = 1'b0;
      tick;
      check("idle_proc_reset", 32'(proc_reset), 32'd0);

      // Back-to-back frame: block k ends with beat 2k+1, conf 11+2k
      o0 = n_out; d0 = n_done; p0 = n_pv;
      run_frame(0, 0, 1'b0, BEATS);
      tick;
      check("f1_busy_after", 32'(busy), 32'd0);
      check_frame("f1", o0, d0, p0, 144);
      check("f1_first_dc", 32'(res_dc[o0 % NRES]), 32'd352);

      // in_valid toggling every other cycle
      o0 = n_out; d0 = n_done; p0 = n_pv;
      run_frame(1, 0, 1'b0, BEATS);
      tick;
      check_frame("f2", o0, d0, p0, 144);

      // Abort after 7 beats
      o0 = n_out; d0 = n_done;
      run_frame(0, 0, 1'b0, 7);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      check("abort_busy",       32'(busy),       32'd0);
      check("abort_proc_reset", 32'(proc_reset), 32'd1);
      check("abort_in_ready",   32'(in_ready),   32'd0);
      tick;
      check("abort_proc_reset_end", 32'(proc_reset), 32'd0);
      repeat (4) tick;
      check("abort_results",    32'(n_out - o0),  32'd3);
      check("abort_no_done",    32'(n_done - d0), 32'd0);

      o0 = n_out; d0 = n_done; p0 = n_pv;
      run_frame(0, 0, 1'b0, BEATS);
      tick;
      check_frame("f3", o0, d0, p0, 144);

      // Stray processor result while idle
      inj = 1'b1;
      #1;
      check("inj_out_valid", 32'(out_valid), 32'd0);
      tick;
      inj = 1'b0;
      check("inj_count_err", 32'(count_err), 32'd1);

      // Frame with block 2 at zero confidence; ALIGN clears count_err
      o0 = n_out; d0 = n_done; p0 = n_pv;
      run_frame(0, 1, 1'b0, BEATS);
      tick;
      check_frame("f4", o0, d0, p0, 280);
`ifdef DISP_SEQ_STATS_EN
      check("stat_zero_blocks", stat_zero_blocks, 32'd1);
      check("stat_conf_sum",    stat_conf_sum,    32'd280);
`endif

      // start held high throughout; only re-honoured after DONE -> IDLE
      o0 = n_out; d0 = n_done; p0 = n_pv;
      run_frame(0, 0, 1'b1, BEATS);
      tick;
      check("hold_idle_busy", 32'(busy), 32'd0);
      tick;
      check("hold_restart_busy",       32'(busy),       32'd1);
      check("hold_restart_proc_reset", 32'(proc_reset), 32'd1);
      start = 1'b0;
      abort = 1'b1;
      tick;
      abort = 1'b0;
      check("hold_abort_busy", 32'(busy), 32'd0);
      tick;
      check_frame("f5", o0, d0, p0, 144);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
